// File: rtl/lfsr_pkg.sv
// Shared types, mode constants and maximal-length tap tables for the PRBS generator.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_e;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    // Fibonacci feedback mask: bit t-1 set for each polynomial tap t.
    function automatic logic [31:0] fib_mask(input int n);
        logic [31:0] m;
        case (n)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // Same polynomial in Galois form: lower-order coefficients, x^0 always present.
    function automatic logic [31:0] gal_poly(input int n);
        logic [32:0] ext;
        ext = {fib_mask(n), 1'b1};
        ext = ext & ((33'd1 << n) - 33'd1);
        return ext[31:0];
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Combinational one-step LFSR advance in Fibonacci or Galois form.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIB
) (
    input  logic [N-1:0] cur_data,
    output logic [N-1:0] next_data
);

    if (MODE == MODE_FIB) begin : g_fib
        localparam logic [N-1:0] FIB_MASK = N'(fib_mask(N));
        assign next_data = {cur_data[N-2:0], ^(cur_data & FIB_MASK)};
    end else begin : g_gal
        localparam logic [N-1:0] GAL_POLY = N'(gal_poly(N));
        assign next_data = (cur_data << 1) ^ (cur_data[N-1] ? GAL_POLY : '0);
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS source: seeded maximal-length LFSR with start/stop FSM and period-done pulse.
// One step per cycle with step_en high in RUN; no backpressure, step_en simply gates advance.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int N          = 8,
    parameter int MODE       = MODE_FIB,
    parameter int CONTINUOUS = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_seed,
    input  logic [N-1:0] seed_data,
    input  logic         start,
    input  logic         stop,
    input  logic         step_en,
    output logic [N-1:0] lfsr_data,
    output logic         lfsr_bit,
    output logic         lfsr_done,
    output logic         busy,
    output logic         seed_err
);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("lfsr_prbs_gen: N must be in 2..32");
    end
    if (MODE != MODE_FIB && MODE != MODE_GAL) begin : g_bad_mode
        $error("lfsr_prbs_gen: MODE must be 0 or 1");
    end

    localparam logic [N-1:0] ONE  = N'(1);
    // Count of the step that completes the period, 2^N - 2 before wrapping.
    localparam logic [N-1:0] LAST = ~ONE;

    lfsr_state_e  state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [N-1:0] next_data;

    lfsr_core #(
        .N    (N),
        .MODE (MODE)
    ) u_core (
        .cur_data  (data_q),
        .next_data (next_data)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (load_seed) begin
                    if (seed_data != '0) begin
                        data_d = seed_data;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Stop wins over a step, including the one that would finish the period.
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (step_en) begin
                    data_d = next_data;
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        if (CONTINUOUS == 0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= ONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign lfsr_data = data_q;
    assign lfsr_bit  = data_q[N-1];
    assign lfsr_done = done_q;
    assign busy      = (state_q == RUN);
    assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Bench for lfsr_prbs_gen: N=4 Fibonacci one-shot and N=8 Galois continuous instances.
module tb_lfsr_prbs_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       ld4, st4, sp4, en4, b4, dn4, bz4, er4;
    logic [3:0] sd4, q4;
    logic       ld8, st8, sp8, en8, b8, dn8, bz8, er8;
    logic [7:0] sd8, q8;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    lfsr_prbs_gen #(.N(4), .MODE(0), .CONTINUOUS(0)) u_dut4 (
        .clk (clk), .reset (reset), .load_seed (ld4), .seed_data (sd4),
        .start (st4), .stop (sp4), .step_en (en4), .lfsr_data (q4),
        .lfsr_bit (b4), .lfsr_done (dn4), .busy (bz4), .seed_err (er4)
    );

    lfsr_prbs_gen #(.N(8), .MODE(1), .CONTINUOUS(1)) u_dut8 (
        .clk (clk), .reset (reset), .load_seed (ld8), .seed_data (sd8),
        .start (st8), .stop (sp8), .step_en (en8), .lfsr_data (q8),
        .lfsr_bit (b8), .lfsr_done (dn8), .busy (bz8), .seed_err (er8)
    );

    // Reference: shift left, feed back the parity of taps 3 and 2.
    function automatic int fib4(input int v);
        return ((v * 2) % 16) + ($countones(v & 12) % 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {ld4, st4, sp4, en4} = 4'b0; sd4 = 4'h0;
        {ld8, st8, sp8, en8} = 4'b0; sd8 = 8'h0;
        repeat (2) tick();
        chk_cnt++; if (q4 !== 4'h1) $display("FAIL reset_data4 got %h want 1", q4); else pass_cnt++;
        chk_cnt++; if ({bz4, dn4, er4, b4} !== 4'b0) $display("FAIL reset_flags4 got %b want 0000", {bz4, dn4, er4, b4}); else pass_cnt++;
        chk_cnt++; if (q8 !== 8'h01) $display("FAIL reset_data8 got %h want 01", q8); else pass_cnt++;
        chk_cnt++; if ({bz8, dn8, er8} !== 3'b0) $display("FAIL reset_flags8 got %b want 000", {bz8, dn8, er8}); else pass_cnt++;
        reset = 1'b1;
        tick();
        chk_cnt++; if (q4 !== 4'h1 || bz4 !== 1'b0) $display("FAIL post_reset4 got %h/%b want 1/0", q4, bz4); else pass_cnt++;
    endtask

    task automatic test_fib_period();
        int exp;
        int spec_seq[7];
        spec_seq = '{1, 2, 4, 9, 3, 6, 13};
        ld4 = 1'b1; sd4 = 4'h1;
        tick();
        ld4 = 1'b0;
        st4 = 1'b1; en4 = 1'b1;
        tick();
        st4 = 1'b0;
        chk_cnt++; if (bz4 !== 1'b1 || q4 !== 4'h1) $display("FAIL start_busy got %b/%h want 1/1", bz4, q4); else pass_cnt++;
        exp = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            exp = fib4(exp);
            chk_cnt++; if (q4 !== 4'(exp)) $display("FAIL fib_data step %0d got %h want %h", i, q4, 4'(exp)); else pass_cnt++;
            if (i < 7) begin
                chk_cnt++; if (q4 !== 4'(spec_seq[i])) $display("FAIL fib_table step %0d got %h want %h", i, q4, 4'(spec_seq[i])); else pass_cnt++;
            end
            chk_cnt++; if (b4 !== 1'((exp >> 3) & 1)) $display("FAIL fib_bit step %0d got %b want %b", i, b4, 1'((exp >> 3) & 1)); else pass_cnt++;
            chk_cnt++; if (dn4 !== (i == 15)) $display("FAIL fib_done step %0d got %b want %b", i, dn4, (i == 15)); else pass_cnt++;
            chk_cnt++; if (bz4 !== (i != 15)) $display("FAIL fib_busy step %0d got %b want %b", i, bz4, (i != 15)); else pass_cnt++;
        end
        en4 = 1'b0;
        tick();
        chk_cnt++; if (dn4 !== 1'b0 || q4 !== 4'h1) $display("FAIL fib_after got %b/%h want 0/1", dn4, q4); else pass_cnt++;
    endtask

    task automatic test_zero_seed();
        ld4 = 1'b1; sd4 = 4'h0;
        tick();
        ld4 = 1'b0;
        chk_cnt++; if (er4 !== 1'b1 || q4 !== 4'h1) $display("FAIL zero_seed got err %b data %h want 1/1", er4, q4); else pass_cnt++;
        tick();
        chk_cnt++; if (er4 !== 1'b1) $display("FAIL zero_sticky got %b want 1", er4); else pass_cnt++;
        ld4 = 1'b1; sd4 = 4'h5;
        tick();
        chk_cnt++; if (er4 !== 1'b0 || q4 !== 4'h5) $display("FAIL seed_reload got err %b data %h want 0/5", er4, q4); else pass_cnt++;
        sd4 = 4'h7; st4 = 1'b1;
        tick();
        ld4 = 1'b0; st4 = 1'b0;
        chk_cnt++; if (q4 !== 4'h7 || bz4 !== 1'b0) $display("FAIL load_start got %h/%b want 7/0", q4, bz4); else pass_cnt++;
    endtask

    task automatic test_gaps(input bit rnd);
        int seed, exp, steps, cyc;
        bit fin, stepped;
        seed = rnd ? int'($urandom_range(1, 15)) : 9;
        ld4 = 1'b1; sd4 = 4'(seed);
        tick();
        ld4 = 1'b0;
        st4 = 1'b1; en4 = 1'b0;
        tick();
        st4 = 1'b0;
        exp = seed; steps = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 200) begin
            en4 = rnd ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
            tick();
            cyc++;
            stepped = en4;
            if (stepped) begin
                exp = fib4(exp);
                steps++;
            end
            fin = (steps == 15) && stepped;
            chk_cnt++; if (q4 !== 4'(exp)) $display("FAIL gap_data cyc %0d got %h want %h", cyc, q4, 4'(exp)); else pass_cnt++;
            chk_cnt++; if (dn4 !== fin) $display("FAIL gap_done cyc %0d got %b want %b", cyc, dn4, fin); else pass_cnt++;
            chk_cnt++; if (bz4 !== !fin) $display("FAIL gap_busy cyc %0d got %b want %b", cyc, bz4, !fin); else pass_cnt++;
        end
        en4 = 1'b0;
        chk_cnt++; if (!fin) $display("FAIL gap_timeout steps %0d want 15", steps); else pass_cnt++;
        chk_cnt++; if (q4 !== 4'(seed)) $display("FAIL gap_wrap got %h want %h", q4, 4'(seed)); else pass_cnt++;
        if (!rnd) begin
            chk_cnt++; if (cyc !== 29) $display("FAIL gap_cycles got %0d want 29", cyc); else pass_cnt++;
        end
    endtask

    task automatic test_stop(input int stop_at);
        int seed, exp;
        seed = int'($urandom_range(1, 15));
        ld4 = 1'b1; sd4 = 4'(seed);
        tick();
        ld4 = 1'b0;
        st4 = 1'b1; en4 = 1'b1;
        tick();
        exp = seed;
        for (int i = 1; i <= stop_at; i++) begin
            ld4 = 1'b1; sd4 = 4'($urandom_range(0, 15)); st4 = 1'b1;
            tick();
            exp = fib4(exp);
            chk_cnt++; if (q4 !== 4'(exp) || dn4 !== 1'b0) $display("FAIL run_ignore step %0d got %h/%b want %h/0", i, q4, dn4, 4'(exp)); else pass_cnt++;
        end
        ld4 = 1'b0; st4 = 1'b0; sp4 = 1'b1;
        tick();
        sp4 = 1'b0;
        chk_cnt++; if (bz4 !== 1'b0 || q4 !== 4'(exp) || dn4 !== 1'b0) $display("FAIL stop_%0d got %b/%h/%b want 0/%h/0", stop_at, bz4, q4, dn4, 4'(exp)); else pass_cnt++;
        tick();
        en4 = 1'b0;
        chk_cnt++; if (bz4 !== 1'b0 || q4 !== 4'(exp) || dn4 !== 1'b0) $display("FAIL stop_hold_%0d got %b/%h/%b want 0/%h/0", stop_at, bz4, q4, dn4, 4'(exp)); else pass_cnt++;
        chk_cnt++; if (er4 !== 1'b0) $display("FAIL stop_err got %b want 0", er4); else pass_cnt++;
    endtask

    task automatic test_continuous();
        bit seen[256];
        int distinct, prev, cur, p, poly;
        ld8 = 1'b1; sd8 = 8'h01;
        tick();
        ld8 = 1'b0;
        st8 = 1'b1; en8 = 1'b1;
        tick();
        st8 = 1'b0;
        distinct = 0; prev = 1; poly = -1;
        for (int s = 1; s <= 510; s++) begin
            tick();
            cur = int'(q8);
            // Galois rule: plain doubling unless the MSB falls out, then a fixed odd polynomial.
            if ((prev & 128) == 0) begin
                chk_cnt++; if (cur != (prev * 2) % 256) $display("FAIL gal_shift step %0d got %h want %h", s, q8, 8'((prev * 2) % 256)); else pass_cnt++;
            end else begin
                p = cur ^ ((prev * 2) % 256);
                if (poly < 0) begin
                    poly = p;
                    chk_cnt++; if ((p & 1) != 1) $display("FAIL gal_poly_odd got %h want odd", 8'(p)); else pass_cnt++;
                end else begin
                    chk_cnt++; if (p != poly) $display("FAIL gal_poly step %0d got %h want %h", s, 8'(p), 8'(poly)); else pass_cnt++;
                end
            end
            chk_cnt++; if (cur == 0) $display("FAIL gal_nonzero step %0d got 00 want nonzero", s); else pass_cnt++;
            if (s <= 255) begin
                if (!seen[cur]) distinct++;
                seen[cur] = 1'b1;
            end
            chk_cnt++; if (dn8 !== (s == 255 || s == 510)) $display("FAIL cont_done step %0d got %b want %b", s, dn8, (s == 255 || s == 510)); else pass_cnt++;
            chk_cnt++; if (bz8 !== 1'b1) $display("FAIL cont_busy step %0d got %b want 1", s, bz8); else pass_cnt++;
            if (s == 255 || s == 510) begin
                chk_cnt++; if (q8 !== 8'h01) $display("FAIL cont_wrap step %0d got %h want 01", s, q8); else pass_cnt++;
            end
            prev = cur;
        end
        chk_cnt++; if (distinct != 255) $display("FAIL cont_distinct got %0d want 255", distinct); else pass_cnt++;
        sp8 = 1'b1;
        tick();
        sp8 = 1'b0; en8 = 1'b0;
        chk_cnt++; if (bz8 !== 1'b0 || dn8 !== 1'b0) $display("FAIL cont_stop got %b/%b want 0/0", bz8, dn8); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        ld4 = 1'b1; sd4 = 4'(int'($urandom_range(2, 15)));
        tick();
        ld4 = 1'b0;
        st4 = 1'b1; en4 = 1'b1;
        tick();
        st4 = 1'b0;
        repeat (14) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_cnt++; if (q4 !== 4'h1 || bz4 !== 1'b0 || dn4 !== 1'b0) $display("FAIL async_reset got %h/%b/%b want 1/0/0", q4, bz4, dn4); else pass_cnt++;
        tick();
        chk_cnt++; if (dn4 !== 1'b0 || q4 !== 4'h1) $display("FAIL reset_hold got %b/%h want 0/1", dn4, q4); else pass_cnt++;
        reset = 1'b1;
        tick();
        en4 = 1'b0;
        chk_cnt++; if (q4 !== 4'h1 || bz4 !== 1'b0 || dn4 !== 1'b0) $display("FAIL reset_release got %h/%b/%b want 1/0/0", q4, bz4, dn4); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fib_period();
        test_zero_seed();
        test_gaps(1'b0);
        test_gaps(1'b1);
        test_stop(7);
        test_stop(14);
        test_continuous();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
